// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline definitions: widths, bubble encoding, boot-state enum, IF/ID payload.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;  // addi x0,x0,0
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } bootState_t;

    // Payload carried from fetch into decode.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pcPlus4;
        logic            valid;
        logic            misalign;
    } ifIdDat_t;

    // Instructions are word-aligned; any low address bit set is a misaligned fetch.
    function automatic logic isMisaligned(input logic [XLEN-1:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register between two stages with flush-over-stall priority.
// Latency: 1 cycle from loadDat to regDat.
// Backpressure: stall holds the current contents; flush overrides stall and inserts BUBBLE.
module if_id_reg
    import rv32_pkg::*;
#(
    parameter ifIdDat_t BUBBLE = '{instr: NOP_INSTR, pc: '0, pcPlus4: '0, valid: 1'b0, misalign: 1'b0}
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     flush,
    input  logic     stall,
    input  ifIdDat_t loadDat,
    output ifIdDat_t regDat
);

    // Reset and flush both produce a bubble; stall freezes; otherwise load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regDat <= BUBBLE;
        end else if (flush) begin
            regDat <= BUBBLE;
        end else if (!stall) begin
            regDat <= loadDat;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, drives the imem read port and fills the IF/ID register.
// Latency: 1 cycle fetch-to-decode; a redirect reaches decode 2 cycles after pc_src_e.
// Backpressure: stall_f holds the PC, stall_d holds IF/ID; flush_d and redirect override stalls.
module fetch_stage #(
    parameter logic [rv32_pkg::XLEN-1:0] RESET_PC  = rv32_pkg::RESET_PC_DEFAULT,
    parameter logic [rv32_pkg::XLEN-1:0] NOP_INSTR = rv32_pkg::NOP_INSTR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_f,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        pc_src_e,
    input  logic [31:0] pc_target_e,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_plus4_d,
    output logic        valid_d,
    output logic        misalign_d
);
    import rv32_pkg::*;

    localparam ifIdDat_t BUBBLE_DAT = '{instr: NOP_INSTR, pc: '0, pcPlus4: '0,
                                        valid: 1'b0, misalign: 1'b0};

    logic [XLEN-1:0] pcF;
    logic [XLEN-1:0] pcPlus4F;
    logic [XLEN-1:0] pcNext;
    logic            misalignF;
    bootState_t      state;
    bootState_t      stateNext;
    logic            bootFlush;
    ifIdDat_t        fetchDat;
    ifIdDat_t        decodeDat;

    assign imem_addr = pcF;
    assign pcPlus4F  = pcF + 32'd4;  // wraps naturally at 2^32
    assign misalignF = isMisaligned(pcF);

    // Next-PC select: a redirect from execute beats a fetch stall.
    always_comb begin
        pcNext = pcPlus4F;
        if (pc_src_e) begin
            pcNext = pc_target_e;
        end else if (stall_f) begin
            pcNext = pcF;
        end
    end

    // Program counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcF <= RESET_PC;
        end else begin
            pcF <= pcNext;
        end
    end

    // Boot state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BOOT;
        end else begin
            state <= stateNext;
        end
    end

    // Boot next-state: spend one edge in BOOT pushing a bubble into decode, then run.
    always_comb begin
        stateNext = state;
        bootFlush = 1'b0;
        case (state)
            BOOT: begin
                stateNext = RUN;
                bootFlush = 1'b1;
            end
            RUN: begin
                stateNext = RUN;
            end
            default: begin
                stateNext = BOOT;
                bootFlush = 1'b1;
            end
        endcase
    end

    // Fetched payload; a misaligned fetch is passed on as a marked NOP so decode can trap.
    always_comb begin
        fetchDat          = BUBBLE_DAT;
        fetchDat.instr    = misalignF ? NOP_INSTR : imem_rdata;
        fetchDat.pc       = pcF;
        fetchDat.pcPlus4  = pcPlus4F;
        fetchDat.valid    = 1'b1;
        fetchDat.misalign = misalignF;
    end

    if_id_reg #(
        .BUBBLE (BUBBLE_DAT)
    ) u_if_id_reg (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush_d | bootFlush),
        .stall   (stall_d),
        .loadDat (fetchDat),
        .regDat  (decodeDat)
    );

    assign instr_d    = decodeDat.instr;
    assign pc_d       = decodeDat.pc;
    assign pc_plus4_d = decodeDat.pcPlus4;
    assign valid_d    = decodeDat.valid;
    assign misalign_d = decodeDat.misalign;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage using a per-cycle expected-value queue.
// Latency: checks outputs 1 ns after each rising edge.
// Backpressure: exercises stall, flush, redirect and asynchronous reset.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stallF;
    logic        stallD;
    logic        flushD;
    logic        pcSrcE;
    logic [31:0] pcTargetE;
    logic [31:0] imemAddr;
    logic [31:0] imemRdata;
    logic [31:0] instrD;
    logic [31:0] pcD;
    logic [31:0] pcPlus4D;
    logic        validD;
    logic        misalignD;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcp4;
        logic [31:0] pcF;
        logic        valid;
        logic        mis;
    } expT;

    expT sbQ[$];
    expT mD;
    logic [31:0] mPc;
    logic        mBoot;

    int checkCnt = 0;
    int errCnt   = 0;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall_f     (stallF),
        .stall_d     (stallD),
        .flush_d     (flushD),
        .pc_src_e    (pcSrcE),
        .pc_target_e (pcTargetE),
        .imem_addr   (imemAddr),
        .imem_rdata  (imemRdata),
        .instr_d     (instrD),
        .pc_d        (pcD),
        .pc_plus4_d  (pcPlus4D),
        .valid_d     (validD),
        .misalign_d  (misalignD)
    );

    // Instruction memory: word[i] = i.
    assign imemRdata = {2'b00, imemAddr[31:2]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clearIn();
        stallF    = 1'b0;
        stallD    = 1'b0;
        flushD    = 1'b0;
        pcSrcE    = 1'b0;
        pcTargetE = 32'h0;
    endtask

    task automatic modelReset();
        mPc      = 32'h0;
        mBoot    = 1'b1;
        mD.instr = NOP;
        mD.pc    = 32'h0;
        mD.pcp4  = 32'h0;
        mD.pcF   = 32'h0;
        mD.valid = 1'b0;
        mD.mis   = 1'b0;
    endtask

    // Predict the post-edge state from current inputs, queue it, clock, then compare.
    task automatic stepCycle(input string tag);
        expT e;
        expT got;
        e = mD;
        if (flushD || mBoot) begin
            e.instr = NOP;
            e.pc    = 32'h0;
            e.pcp4  = 32'h0;
            e.valid = 1'b0;
            e.mis   = 1'b0;
        end else if (!stallD) begin
            e.pc    = mPc;
            e.pcp4  = mPc + 32'd4;
            e.mis   = (mPc[1:0] != 2'b00);
            e.instr = e.mis ? NOP : (mPc >> 2);
            e.valid = 1'b1;
        end
        if (pcSrcE)       e.pcF = pcTargetE;
        else if (stallF)  e.pcF = mPc;
        else              e.pcF = mPc + 32'd4;
        mD    = e;
        mPc   = e.pcF;
        mBoot = 1'b0;
        sbQ.push_back(e);

        @(posedge clk);
        #1;
        got = sbQ.pop_front();
        checkVal({tag, ".imem_addr"}, imemAddr, got.pcF);
        checkVal({tag, ".instr_d"}, instrD, got.instr);
        checkVal({tag, ".pc_d"}, pcD, got.pc);
        checkVal({tag, ".pc_plus4_d"}, pcPlus4D, got.pcp4);
        checkVal({tag, ".valid_d"}, 32'(validD), 32'(got.valid));
        checkVal({tag, ".misalign_d"}, 32'(misalignD), 32'(got.mis));
        clearIn();
    endtask

    initial begin
        rst = 1'b0;
        clearIn();
        modelReset();
        repeat (2) @(posedge clk);
        #1;

        // Reset state.
        checkVal("rst.imem_addr", imemAddr, 32'h0);
        checkVal("rst.instr_d", instrD, NOP);
        checkVal("rst.valid_d", 32'(validD), 32'h0);
        checkVal("rst.pc_d", pcD, 32'h0);
        checkVal("rst.pc_plus4_d", pcPlus4D, 32'h0);
        checkVal("rst.misalign_d", 32'(misalignD), 32'h0);

        // Release with no stalls: boot edge inserts a bubble while the PC advances.
        rst = 1'b1;
        stepCycle("boot1");
        checkVal("boot1.valid", 32'(validD), 32'h0);
        checkVal("boot1.instr", instrD, NOP);
        checkVal("boot1.pcf", imemAddr, 32'h4);
        stepCycle("run1");
        checkVal("run1.pc_d", pcD, 32'h4);
        checkVal("run1.instr", instrD, 32'h1);
        checkVal("run1.pcf", imemAddr, 32'h8);

        // Load-use style stall for two cycles at pc_f = 8.
        for (int i = 0; i < 2; i++) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stepCycle("stall");
            checkVal("stall.pcf", imemAddr, 32'h8);
            checkVal("stall.pc_d", pcD, 32'h4);
        end
        stepCycle("unstall1");
        checkVal("unstall1.pc_d", pcD, 32'h8);
        stepCycle("unstall2");
        checkVal("unstall2.pc_d", pcD, 32'hC);

        // Taken branch with flush.
        pcSrcE = 1'b1; pcTargetE = 32'h40; flushD = 1'b1;
        stepCycle("br1");
        checkVal("br1.pcf", imemAddr, 32'h40);
        checkVal("br1.valid", 32'(validD), 32'h0);
        stepCycle("br2");
        checkVal("br2.pc_d", pcD, 32'h40);
        checkVal("br2.valid", 32'(validD), 32'h1);

        // Redirect beats stall_f, flush beats stall_d.
        pcSrcE = 1'b1; pcTargetE = 32'h80; flushD = 1'b1; stallF = 1'b1; stallD = 1'b1;
        stepCycle("simul");
        checkVal("simul.pcf", imemAddr, 32'h80);
        checkVal("simul.instr", instrD, NOP);
        checkVal("simul.valid", 32'(validD), 32'h0);

        // Stall of decode alone holds IF/ID while PC advances.
        stepCycle("pre_sd");
        stallD = 1'b1;
        stepCycle("sd_only");
        checkVal("sd_only.pc_d", pcD, 32'h80);
        checkVal("sd_only.pcf", imemAddr, 32'h88);

        // Misaligned target.
        pcSrcE = 1'b1; pcTargetE = 32'h42; flushD = 1'b1;
        stepCycle("mis0");
        stepCycle("mis1");
        checkVal("mis1.pc_d", pcD, 32'h42);
        checkVal("mis1.instr", instrD, NOP);
        checkVal("mis1.valid", 32'(validD), 32'h1);
        checkVal("mis1.misalign", 32'(misalignD), 32'h1);
        stepCycle("mis2");
        checkVal("mis2.pc_d", pcD, 32'h46);

        // PC wrap at the top of the address space.
        pcSrcE = 1'b1; pcTargetE = 32'hFFFF_FFFC; flushD = 1'b1;
        stepCycle("wrap0");
        stepCycle("wrap1");
        checkVal("wrap1.pc_plus4_d", pcPlus4D, 32'h0);
        checkVal("wrap1.pcf", imemAddr, 32'h0);

        // Reach pc_f = 0x20 with a valid instruction in decode.
        pcSrcE = 1'b1; pcTargetE = 32'h1C; flushD = 1'b1;
        stepCycle("pre20a");
        stepCycle("pre20b");
        checkVal("pre20.pcf", imemAddr, 32'h20);
        checkVal("pre20.valid", 32'(validD), 32'h1);

        // Asynchronous reset mid-cycle.
        #3;
        rst = 1'b0;
        #1;
        checkVal("arst.pcf", imemAddr, 32'h0);
        checkVal("arst.valid", 32'(validD), 32'h0);
        checkVal("arst.instr", instrD, NOP);
        modelReset();
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Reboot holding the PC across the boot edge so word 0 reaches decode.
        stallF = 1'b1;
        stepCycle("reboot1");
        checkVal("reboot1.valid", 32'(validD), 32'h0);
        checkVal("reboot1.pcf", imemAddr, 32'h0);
        stepCycle("reboot2");
        checkVal("reboot2.pc_d", pcD, 32'h0);
        checkVal("reboot2.instr", instrD, 32'h0);
        checkVal("reboot2.valid", 32'(validD), 32'h1);
        stepCycle("reboot3");
        checkVal("reboot3.pc_d", pcD, 32'h4);

        checkVal("sb.empty", 32'(sbQ.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
        $finish;
    end

endmodule
